hex_display_scan: RTL

Time-multiplexed hexadecimal 7-segment driver for the board display bank: shows a `DIGITS`-nibble value on one shared segment bus, scanning one digit per refresh slot. This is the parametrised successor of the per-digit PC/register display decoder. Additions over that decoder:
- double-buffered loading, so no frame ever shows a mix of old and new nibbles;
- optional leading-zero blanking;
- a blink mode used to flag end-of-program.

---
 rtl/hex_display_scan_if.sv | 27 ++
 rtl/hex_display_scan.sv | 139 +++++++++++++
 2 files changed

// File: rtl/hex_display_scan_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hex_display_scan_if: value/control inputs and scan outputs            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface hex_display_scan_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] value;
  logic                load;
  logic                blank_lz;
  logic                blink_en;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   an;
  logic                frame_done;

  modport master (
    output value, load, blank_lz, blink_en,
    input  seg, an, frame_done
  );

  modport slave (
    input  value, load, blank_lz, blink_en,
    output seg, an, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/hex_display_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hex_display_scan: multiplexed hex 7-segment driver, double-buffered   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hex_display_scan #(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 64
) (
  input  logic                clk,
  input  logic                rst,
  hex_display_scan_if.slave   bus
);

  localparam int DIV_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1)      ? $clog2(DIGITS)      : 1;
  localparam int BCNT_W = (BLINK_DIV > 1)   ? $clog2(BLINK_DIV)   : 1;
  localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(DIGITS - 1);
  localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(BLINK_DIV - 1);

  logic [DIV_W-1:0]    div_q, div_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] active_q, active_d;
  logic [4*DIGITS-1:0] pending_q, pending_d;
  logic                pend_v_q, pend_v_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic                phase_q, phase_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_done_q;

  logic                tick;
  logic                boundary;
  logic [DIGITS-1:0]   lz_zero;
  logic                lz_run;
  logic [3:0]          nibble;
  logic                dark;

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 7'b1000000;
      4'h1: font = 7'b1111001;
      4'h2: font = 7'b0100100;
      4'h3: font = 7'b0110000;
      4'h4: font = 7'b0011001;
      4'h5: font = 7'b0010010;
      4'h6: font = 7'b0000010;
      4'h7: font = 7'b1111000;
      4'h8: font = 7'b0000000;
      4'h9: font = 7'b0010000;
      4'hA: font = 7'b0001000;
      4'hB: font = 7'b0000011;
      4'hC: font = 7'b1000110;
      4'hD: font = 7'b0100001;
      4'hE: font = 7'b0000110;
      default: font = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    tick     = (div_q == DIV_MAX);
    boundary = tick && (idx_q == IDX_MAX);
    div_d    = tick ? '0 : div_q + DIV_W'(1);
    idx_d    = idx_q;
    if (tick) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);

    // A load coinciding with the boundary bypasses the pending buffer.
    active_d  = active_q;
    pending_d = pending_q;
    pend_v_d  = pend_v_q;
    if (bus.load) begin
      pending_d = bus.value;
      pend_v_d  = 1'b1;
    end
    if (boundary) begin
      pend_v_d = 1'b0;
      if (bus.load)      active_d = bus.value;
      else if (pend_v_q) active_d = pending_q;
    end

    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (boundary) begin
      if (bcnt_q == BCNT_MAX) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BCNT_W'(1);
      end
    end

    // lz_zero[i]: nibbles i..DIGITS-1 of the next active value are all zero.
    lz_run = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_run     = lz_run & (active_d[4*i +: 4] == 4'h0);
      lz_zero[i] = lz_run;
    end

    nibble = active_d[{idx_d, 2'b00} +: 4];
    dark   = (bus.blink_en && phase_d) ||
             (bus.blank_lz && (idx_d != '0) && lz_zero[idx_d]);
    seg_d  = dark ? 7'b1111111 : font(nibble);
    an_d   = dark ? '1 : ~(DIGITS'(1) << idx_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q        <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      pending_q    <= '0;
      pend_v_q     <= 1'b0;
      bcnt_q       <= '0;
      phase_q      <= 1'b0;
      seg_q        <= 7'b1111111;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      pend_v_q     <= pend_v_d;
      bcnt_q       <= bcnt_d;
      phase_q      <= phase_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= boundary;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire
